// File: rtl/endpoint_detector.sv
// endpoint_detector: dual-threshold hysteresis voice-activity detector.
// Sits after moving_average; debounces onset (MIN_ON loud samples) and
// applies a hangover (HANGOVER quiet samples) before closing a segment.
// Reports the start/end sample indices and an active flag, all registered.
module endpoint_detector #(
   parameter int                    DATA_WIDTH = 16,
   parameter int                    IDX_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0] ON_THRESH  = 16'd1000,
   parameter logic [DATA_WIDTH-1:0] OFF_THRESH = 16'd500,
   parameter int                    MIN_ON     = 4,
   parameter int                    HANGOVER   = 8,
   parameter int                    CNT_WIDTH  = 16
) (
   input  logic                  iclk,
   input  logic                  irst,
   input  logic [DATA_WIDTH-1:0] idata,
   input  logic                  ivalid,
   input  logic [IDX_WIDTH-1:0]  iidx,
   output logic                  oactive,
   output logic                  ostart_valid,
   output logic [IDX_WIDTH-1:0]  ostart_idx,
   output logic                  oend_valid,
   output logic [IDX_WIDTH-1:0]  oend_idx
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ONSET = 2'd1,
      S_ACTV  = 2'd2,
      S_HANG  = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] C_MIN_ON = CNT_WIDTH'(MIN_ON);
   localparam logic [CNT_WIDTH-1:0] C_HANG   = CNT_WIDTH'(HANGOVER);
   localparam logic [CNT_WIDTH-1:0] C_ONE    = CNT_WIDTH'(1);

   state_t                 r_state;
   logic [CNT_WIDTH-1:0]   r_cnt;
   logic [IDX_WIDTH-1:0]   r_cand_idx;
   logic [IDX_WIDTH-1:0]   r_last_idx;
   logic                   r_active;
   logic                   r_start_valid;
   logic [IDX_WIDTH-1:0]   r_start_idx;
   logic                   r_end_valid;
   logic [IDX_WIDTH-1:0]   r_end_idx;

   logic                   w_loud;
   logic                   w_quiet;
   logic                   w_restart;
   logic                   w_close;
   state_t                 w_eff_state;
   logic [CNT_WIDTH-1:0]   w_cnt_inc;

   assign w_loud    = (idata >= ON_THRESH);
   assign w_quiet   = (idata <  OFF_THRESH);
   assign w_restart = (iidx == '0);
   // A new stream closes any open segment, then the sample is judged from IDLE.
   assign w_close     = w_restart && (r_state == S_ACTV || r_state == S_HANG);
   assign w_eff_state = w_restart ? S_IDLE : r_state;
   // Saturating increment so a stuck counter can never wrap back to zero.
   assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + C_ONE;

   // Endpoint FSM with registered pulses, indices and active flag.
   always_ff @(posedge iclk) begin
      if (irst) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_cand_idx    <= '0;
         r_last_idx    <= '0;
         r_active      <= 1'b0;
         r_start_valid <= 1'b0;
         r_start_idx   <= '0;
         r_end_valid   <= 1'b0;
         r_end_idx     <= '0;
      end else begin
         r_start_valid <= 1'b0;
         r_end_valid   <= 1'b0;
         if (ivalid) begin
            if (w_close) begin
               r_end_valid <= 1'b1;
               r_end_idx   <= r_last_idx;
            end
            case (w_eff_state)
               S_IDLE: begin
                  if (w_loud) begin
                     r_cand_idx <= iidx;
                     r_cnt      <= C_ONE;
                     if (MIN_ON == 1) begin
                        r_state       <= S_ACTV;
                        r_active      <= 1'b1;
                        r_start_valid <= 1'b1;
                        r_start_idx   <= iidx;
                        r_last_idx    <= iidx;
                     end else begin
                        r_state  <= S_ONSET;
                        r_active <= 1'b0;
                     end
                  end else begin
                     r_state  <= S_IDLE;
                     r_cnt    <= '0;
                     r_active <= 1'b0;
                  end
               end
               S_ONSET: begin
                  if (w_loud) begin
                     r_cnt <= w_cnt_inc;
                     if (w_cnt_inc == C_MIN_ON) begin
                        r_state       <= S_ACTV;
                        r_active      <= 1'b1;
                        r_start_valid <= 1'b1;
                        r_start_idx   <= r_cand_idx;
                        r_last_idx    <= iidx;
                     end
                  end else begin
                     r_state <= S_IDLE;
                     r_cnt   <= '0;
                  end
               end
               S_ACTV: begin
                  if (!w_quiet) begin
                     r_last_idx <= iidx;
                  end else begin
                     r_cnt <= C_ONE;
                     if (HANGOVER == 1) begin
                        r_state     <= S_IDLE;
                        r_active    <= 1'b0;
                        r_end_valid <= 1'b1;
                        r_end_idx   <= r_last_idx;
                     end else begin
                        r_state <= S_HANG;
                     end
                  end
               end
               S_HANG: begin
                  if (!w_quiet) begin
                     r_state    <= S_ACTV;
                     r_cnt      <= '0;
                     r_last_idx <= iidx;
                  end else begin
                     r_cnt <= w_cnt_inc;
                     if (w_cnt_inc == C_HANG) begin
                        r_state     <= S_IDLE;
                        r_active    <= 1'b0;
                        r_end_valid <= 1'b1;
                        r_end_idx   <= r_last_idx;
                     end
                  end
               end
               default: begin
                  r_state  <= S_IDLE;
                  r_cnt    <= '0;
                  r_active <= 1'b0;
               end
            endcase
         end
      end
   end

   assign oactive      = r_active;
   assign ostart_valid = r_start_valid;
   assign ostart_idx   = r_start_idx;
   assign oend_valid   = r_end_valid;
   assign oend_idx     = r_end_idx;

endmodule

// File: doc/endpoint_detector.md
Name: endpoint_detector

Overview:
Speech endpoint (voice-activity) detector placed directly downstream of moving_average. It consumes the smoothed magnitude stream (odata/ovalid/oidx of moving_average) and applies dual-threshold hysteresis with debounce and hangover. It reports the sample index at which an utterance starts and ends, and flags the active region for the feature-extraction stages that follow.

Parameters:
DATA_WIDTH, 16, width of idata (unsigned)
IDX_WIDTH, 32, width of iidx/ostart_idx/oend_idx
ON_THRESH, 16'd1000, onset level; idata >= ON_THRESH counts as "loud"
OFF_THRESH, 16'd500, release level; idata < OFF_THRESH counts as "quiet"; must be <= ON_THRESH
MIN_ON, 4, consecutive loud samples needed to declare a start (>=1)
HANGOVER, 8, consecutive quiet samples needed to declare an end (>=1)
CNT_WIDTH, 16, debounce/hangover counter width; must hold max(MIN_ON, HANGOVER)

Ports:
iclk  input  1  clock
irst  input  1  synchronous reset, active-high
idata  input  DATA_WIDTH  smoothed magnitude sample, unsigned
ivalid  input  1  idata/iidx valid this cycle
iidx  input  IDX_WIDTH  sample index; 0 marks the start of a new stream
oactive  output  1  high while in ACTIVE or HANGOVER
ostart_valid  output  1  one-cycle pulse: segment start declared
ostart_idx  output  IDX_WIDTH  index of first loud sample of the declared segment
oend_valid  output  1  one-cycle pulse: segment end declared
oend_idx  output  IDX_WIDTH  index of last non-quiet sample of the segment

Behaviour:
- Reset: synchronous on posedge iclk while irst=1; state=IDLE, counters=0, all outputs 0. Reset mid-segment emits no end pulse.
- Only cycles with ivalid=1 advance the FSM. ivalid=0 cycles hold state, counters and index outputs. Pulses are forced to 0 on these cycles.
- All outputs are registered. Response appears on the cycle after the accepted sample (latency 1).
- ostart_valid/oend_valid are high for exactly one cycle. ostart_idx/oend_idx hold their values until the next pulse overwrites them.
- Comparisons are unsigned. "Loud" means idata >= ON_THRESH. "Quiet" means idata < OFF_THRESH.
- FSM states:
  - IDLE:
    - Loud: cand_idx=iidx, cnt=1.
    - If MIN_ON==1: go to ACTIVE, fire start, last_idx=iidx. Otherwise go to ONSET.
    - Not loud: stay in IDLE.
  - ONSET:
    - Loud: cnt+1. When cnt+1==MIN_ON: go to ACTIVE, ostart_valid=1, ostart_idx=cand_idx, last_idx=iidx.
    - Not loud: go to IDLE, cnt=0, no pulse.
  - ACTIVE:
    - Not quiet: last_idx=iidx.
    - Quiet: cnt=1. If HANGOVER==1: go to IDLE, fire end. Otherwise go to HANGOVER.
  - HANGOVER:
    - Not quiet: go to ACTIVE, cnt=0, last_idx=iidx.
    - Quiet: cnt+1. When cnt+1==HANGOVER: go to IDLE, oend_valid=1, oend_idx=last_idx.
- Stream restart: an accepted sample with iidx==0 while in ACTIVE or HANGOVER closes the open segment first (oend_valid=1, oend_idx=last_idx). That same sample is then evaluated as if from IDLE.
  - If it is loud and MIN_ON==1, start and end pulse on the same cycle; ostart_idx=0.
  - iidx==0 in ONSET discards the candidate and re-evaluates from IDLE.
- Counters saturate and never wrap. Index outputs are pass-through copies; no arithmetic on iidx.
- Thresholds in the band OFF_THRESH <= idata < ON_THRESH: neither starts nor ends a segment; they keep ACTIVE alive.

Test Plan:
All scenarios use ON_THRESH=100, OFF_THRESH=50, MIN_ON=3, HANGOVER=2, ivalid=1 every cycle unless stated.
1. Reset: hold irst=1 for 2 cycles, then release -> oactive=0, ostart_valid=0, oend_valid=0, ostart_idx=0, oend_idx=0.
2. Start: idata 0,120,130,140,150 at idx 0..4 -> single ostart_valid pulse one cycle after idx3, ostart_idx=1; oactive=1 from then on.
3. Debounce reject: idata 10,120,130,20,10 -> no pulses, oactive stays 0.
4. End: after start, idata 80,60,40,30 at idx 5..8 -> oend_valid pulse one cycle after idx8, oend_idx=6; oactive drops to 0 with the pulse.
5. Hangover recovery plus gaps:
   - After start, idata 40 then 70 -> no end pulse, oactive stays 1.
   - Insert 3 cycles of ivalid=0 mid-ONSET -> state held; start fires on the next loud valid sample.
6. Restart and reset:
   - While ACTIVE with last_idx=9, send iidx=0 with idata=10 -> oend_valid=1, oend_idx=9, state IDLE.
   - Then re-enter ACTIVE and assert irst -> no oend pulse, all outputs 0.
